// File: rtl/ped_pkg.sv
// Shared types and defaults for the pedestrian request conditioner.
// Holds the FSM state encoding, default timing constants and a saturating-increment helper.
// No ports; imported by the conditioner top and the debouncer.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVE   = 2'd2,
        LOCKOUT = 2'd3
    } ped_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int LOCKOUT_CYCLES_DEF  = 8;

    // Eight-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ped_request_conditioner_if.sv
// Pedestrian panel bundle: raw button and walk acknowledge in, request and WAIT lamp out.
// slave = conditioner side, master = controller/panel side.
// press_count exists only when PED_PRESS_STATS_EN is defined.
interface ped_request_conditioner_if;
    logic btn_raw;
    logic ped_walk;
    logic ped_button;
    logic wait_lamp;
`ifdef PED_PRESS_STATS_EN
    logic [7:0] press_count;

    modport master (output btn_raw, output ped_walk,
                    input ped_button, input wait_lamp, input press_count);
    modport slave  (input btn_raw, input ped_walk,
                    output ped_button, output wait_lamp, output press_count);
`else
    modport master (output btn_raw, output ped_walk,
                    input ped_button, input wait_lamp);
    modport slave  (input btn_raw, input ped_walk,
                    output ped_button, output wait_lamp);
`endif
endinterface

// File: rtl/ped_request_conditioner_debounce.sv
// Two-flop synchronizer plus counter debouncer; rise pulses once per accepted 0->1 of dout.
// Latency: dout/rise update DEBOUNCE_CYCLES+2 edges after din first sampled at a new level.
// No backpressure; free-running. Ports: clk, reset, din (async), dout (level), rise (1-cycle pulse).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [1:0] fill;
    logic       armed;
    logic       btn_db;
    logic [7:0] stab_cnt;

    // fill marks when sync2 carries a genuine sample after reset. armed is set
    // only once the synchronized input has been seen low, so a button held
    // through reset cannot produce a press until it is released and re-pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            fill     <= 2'b00;
            armed    <= 1'b0;
            btn_db   <= 1'b0;
            stab_cnt <= 8'd0;
            rise     <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~sync2);
            rise  <= 1'b0;
            if (sync2 != btn_db) begin
                if (stab_cnt == CNT_LAST) begin
                    btn_db   <= sync2;
                    stab_cnt <= 8'd0;
                    rise     <= sync2 & armed;
                end else begin
                    stab_cnt <= stab_cnt + 8'd1;
                end
            end else begin
                stab_cnt <= 8'd0;
            end
        end
    end

    assign dout = btn_db;

endmodule

// File: rtl/ped_request_conditioner.sv
// Turns a bouncy pedestrian button into a single held request, cleared by the walk acknowledge.
// Latency: ped_button rises DEBOUNCE_CYCLES+3 edges after btn_raw is first sampled high (from IDLE).
// No backpressure; presses outside IDLE are dropped. Ports: clk, reset, bus (slave: btn_raw,
// ped_walk in; ped_button, wait_lamp out; press_count out when PED_PRESS_STATS_EN is defined).
module ped_request_conditioner
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    ped_request_conditioner_if.slave  bus
);

    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES - 1);

    ped_state_t state;
    ped_state_t state_nxt;
    logic [7:0] lock_cnt;
    logic [7:0] lock_nxt;
    logic       btn_db;
    logic       db_rise;
    logic       press;
    logic       accept;
    logic       ped_button_q;
    logic       wait_lamp_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (bus.btn_raw),
        .dout  (btn_db),
        .rise  (db_rise)
    );

    // rise is registered alongside the debounced level, so both are high together.
    assign press = db_rise & btn_db;

    // Lockout counter is only non-zero while in LOCKOUT; every other path loads 0.
    always_comb begin
        state_nxt = state;
        lock_nxt  = 8'd0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nxt = REQ;
                    accept    = 1'b1;
                end
            end
            REQ: begin
                if (bus.ped_walk) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (!bus.ped_walk) begin
                    state_nxt = LOCKOUT;
                    lock_nxt  = LOCK_LOAD;
                end
            end
            LOCKOUT: begin
                if (lock_cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    lock_nxt = lock_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are flops loaded from the next state so they change on the same
    // edge as the state register and have no path from the inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lock_cnt     <= 8'd0;
            ped_button_q <= 1'b0;
            wait_lamp_q  <= 1'b0;
        end else begin
            state        <= state_nxt;
            lock_cnt     <= lock_nxt;
            ped_button_q <= (state_nxt == REQ);
            wait_lamp_q  <= (state_nxt == REQ);
        end
    end

    assign bus.ped_button = ped_button_q;
    assign bus.wait_lamp  = wait_lamp_q;

`ifdef PED_PRESS_STATS_EN
    logic [7:0] press_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            press_cnt <= 8'd0;
        end else if (accept) begin
            press_cnt <= sat_inc8(press_cnt);
        end
    end

    assign bus.press_count = press_cnt;
`else
    // accept only feeds the optional press statistics.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner: directed scenarios plus randomized button/walk traffic
// compared each cycle against a behavioural model (sample window debounce, phase + countdown).
// Inputs change on the falling edge; outputs are compared 1 time unit after the rising edge.
module tb_ped_request_conditioner;

    localparam int D = 4;
    localparam int L = 8;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_SERVE = 2, PH_LOCK = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ped_request_conditioner_if bus();

    ped_request_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LOCKOUT_CYCLES  (L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_k;          // edges since reset
    bit m_r1, m_r2;   // raw input as sampled one and two edges ago
    bit m_db;         // debounced level
    bit m_rise;       // press visible to the request logic this cycle
    bit m_seen_low;   // button observed released since reset
    bit m_win[$];     // synchronized samples since the debounced level last changed
    int m_phase;
    int m_left;       // lockout cycles still to run
    int m_presses;

    task automatic model_reset();
        m_k = 0; m_r1 = 0; m_r2 = 0; m_db = 0; m_rise = 0; m_seen_low = 0;
        m_win.delete(); m_phase = PH_IDLE; m_left = 0; m_presses = 0;
    endtask

    task automatic model_edge(input bit raw, input bit walk, input bit rst);
        bit s;
        bit new_rise;
        bit all_diff;
        if (rst) begin
            model_reset();
            return;
        end
        m_k++;
        s = m_r2;
        case (m_phase)
            PH_IDLE:  if (m_rise) begin
                          m_phase = PH_REQ;
                          if (m_presses < 255) m_presses++;
                      end
            PH_REQ:   if (walk) m_phase = PH_SERVE;
            PH_SERVE: if (!walk) begin m_phase = PH_LOCK; m_left = L; end
            default:  begin
                          m_left--;
                          if (m_left == 0) m_phase = PH_IDLE;
                      end
        endcase
        new_rise = 0;
        m_win.push_back(s);
        if (m_win.size() >= D) begin
            all_diff = 1;
            for (int j = m_win.size() - D; j < m_win.size(); j++)
                if (m_win[j] == m_db) all_diff = 0;
            if (all_diff) begin
                if (!m_db && m_seen_low) new_rise = 1;
                m_db = !m_db;
                m_win.delete();
            end
        end
        if (m_k >= 3 && !s) m_seen_low = 1;
        m_rise = new_rise;
        m_r2 = m_r1;
        m_r1 = raw;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit raw, input bit walk, input bit rst);
        @(negedge clk);
        bus.btn_raw  = raw;
        bus.ped_walk = walk;
        reset        = rst;
        @(posedge clk);
        model_edge(raw, walk, rst);
        #1;
        check("ped_button", 32'(bus.ped_button), 32'(m_phase == PH_REQ));
        check("wait_lamp",  32'(bus.wait_lamp),  32'(m_phase == PH_REQ));
`ifdef PED_PRESS_STATS_EN
        check("press_count", 32'(bus.press_count), 32'(m_presses));
`endif
    endtask

    // Holds the button down and returns the edge count to ped_button high (0 if the budget runs out).
    task automatic press_latency(input bit walk, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, walk, 1'b0);
            if (bus.ped_button === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen_high;
        bit  raw, walk, rst, lvl, bnc;
        int  seg;

        model_reset();
        bus.btn_raw  = 1'b0;
        bus.ped_walk = 1'b0;
        reset        = 1'b1;

        // Reset state
        step(0, 0, 1);
        step(0, 0, 1);
        check("reset_ped_button", 32'(bus.ped_button), 32'd0);
        check("reset_wait_lamp",  32'(bus.wait_lamp),  32'd0);
        repeat (5) step(0, 0, 0);

        // Clean press, then acknowledge
        press_latency(0, n);
        check("clean_press_latency", 32'(n), 32'(D + 3));
        check("clean_wait_lamp", 32'(bus.wait_lamp), 32'd1);
        step(1, 1, 0);
        check("ack_ped_button", 32'(bus.ped_button), 32'd0);
        check("ack_wait_lamp",  32'(bus.wait_lamp),  32'd0);

        // Release and re-press while served, so the new press lands inside lockout
        repeat (8) step(0, 1, 0);
        repeat (3) step(1, 1, 0);
        seen_high = 0;
        repeat (12) begin
            step(1, 0, 0);
            if (bus.ped_button === 1'b1) seen_high = 1;
        end
        check("lockout_no_request", 32'(seen_high), 32'd0);
        repeat (8) step(0, 0, 0);
        press_latency(0, n);
        check("post_lockout_latency", 32'(n), 32'(D + 3));
        step(1, 1, 0);
        repeat (8) step(0, 1, 0);
        repeat (L + 4) step(0, 0, 0);

        // Bounce: toggling every cycle never settles
        seen_high = 0;
        for (int i = 0; i < 10; i++) begin
            step(bit'(i % 2 == 0), 0, 0);
            if (bus.ped_button === 1'b1) seen_high = 1;
        end
        repeat (10) begin
            step(0, 0, 0);
            if (bus.ped_button === 1'b1) seen_high = 1;
        end
        check("bounce_no_request", 32'(seen_high), 32'd0);

        // Walk alone in IDLE ignored; press and walk in the same IDLE cycle
        seen_high = 0;
        repeat (D + 2) begin
            step(1, 1, 0);
            if (bus.ped_button === 1'b1) seen_high = 1;
        end
        check("walk_alone_idle", 32'(seen_high), 32'd0);
        step(1, 1, 0);
        check("simul_req", 32'(bus.ped_button), 32'd1);
        step(1, 1, 0);
        check("simul_serve", 32'(bus.ped_button), 32'd0);
        repeat (8) step(0, 1, 0);
        repeat (L + 4) step(0, 0, 0);

        // Reset in REQ with the button still held
        press_latency(0, n);
        check("pre_reset_latency", 32'(n), 32'(D + 3));
        step(1, 0, 1);
        check("reset_req_ped_button", 32'(bus.ped_button), 32'd0);
        check("reset_req_wait_lamp",  32'(bus.wait_lamp),  32'd0);
        seen_high = 0;
        repeat (20) begin
            step(1, 0, 0);
            if (bus.ped_button === 1'b1) seen_high = 1;
        end
        check("held_after_reset", 32'(seen_high), 32'd0);
        repeat (10) step(0, 0, 0);
        press_latency(0, n);
        check("repress_latency", 32'(n), 32'(D + 3));
        step(1, 1, 0);
        repeat (8) step(0, 1, 0);
        repeat (L + 4) step(0, 0, 0);

        // Randomized traffic against the model
        walk = 0;
        seg  = 0;
        lvl  = 0;
        bnc  = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                lvl = bit'($urandom_range(0, 1));
                bnc = ($urandom_range(0, 2) == 0);
                seg = int'($urandom_range(1, 15));
            end
            seg--;
            raw = lvl ^ (bnc && ($urandom_range(0, 2) == 0));
            if (m_phase == PH_REQ && !walk)
                walk = ($urandom_range(0, 3) == 0);
            else if (walk)
                walk = ($urandom_range(0, 2) != 0);
            else
                walk = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step(raw, walk, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ped_request_conditioner.md
PED_REQUEST_CONDITIONER -- requirements
Module: ped_request_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required before the debounced level changes (legal range 1..255).
REQ-002 Parameter LOCKOUT_CYCLES, default 8: cycles after a walk phase ends during which new presses are discarded (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_raw  input  1  raw pedestrian push-button, asynchronous, may bounce.
REQ-006 ped_walk  input  1  walk indication returned from traffic_light_controller; serves as request acknowledge.
REQ-007 ped_button  output  1  registered pedestrian request level driven into traffic_light_controller.
REQ-008 wait_lamp  output  1  registered "WAIT" indicator for the pedestrian panel.

Function
REQ-009 btn_raw SHALL pass through a two-flop synchronizer before any other use.
REQ-010 Debounced level btn_db SHALL change only after the synchronized input differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free sample resets the stability counter to zero.
REQ-011 A press SHALL be the cycle in which btn_db transitions 0->1; 1->0 transitions generate nothing.
REQ-012 With btn_raw held high, ped_button SHALL rise exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling btn_raw high, when the FSM is IDLE.
REQ-013 FSM states: IDLE, REQ, SERVE, LOCKOUT.
REQ-014 IDLE: ped_button=0, wait_lamp=0; press -> REQ; ped_walk alone is ignored (stay IDLE).
REQ-015 REQ: ped_button=1, wait_lamp=1; ped_walk=1 -> SERVE; further presses are ignored (no queueing).
REQ-016 SERVE: ped_button=0, wait_lamp=0; ped_walk=0 -> LOCKOUT, loading lockout counter with LOCKOUT_CYCLES-1.
REQ-017 LOCKOUT: outputs 0; counter decrements each cycle; at counter 0 -> IDLE; presses in SERVE or LOCKOUT SHALL be discarded.
REQ-018 A press and ped_walk=1 in the same IDLE cycle SHALL move to REQ; SERVE is entered on the next cycle if ped_walk is still 1.
REQ-019 Outputs SHALL be decoded from registered state only (no combinational path from btn_raw or ped_walk to outputs).
REQ-020 Counters SHALL not wrap: stability counter clears on match; lockout counter holds at 0 outside LOCKOUT.

Reset
REQ-021 While reset=1 at a clock edge: state=IDLE, synchronizer flops=0, btn_db=0, all counters=0, ped_button=0, wait_lamp=0.
REQ-022 Reset asserted in any state, including mid-debounce or mid-LOCKOUT, SHALL abandon the pending request with no press generated after release unless btn_raw is re-debounced high from 0.

Configuration
REQ-023 Macro PED_PRESS_STATS_EN defined: adds output press_count [7:0], incremented on every accepted press (IDLE->REQ), saturating at 255, cleared by reset.
REQ-024 Macro undefined: press_count port and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-025 Shared package ped_pkg SHALL hold the FSM state encoding (2-bit enum IDLE=0, REQ=1, SERVE=2, LOCKOUT=3) and default DEBOUNCE_CYCLES/LOCKOUT_CYCLES constants.
REQ-026 Synchronizer plus debouncer SHALL be a sub-module btn_debounce (ports clk, reset, din, dout, rise), instantiated once.

Verification
REQ-027 Clean press: defaults, btn_raw 0->1 held -> ped_button=1 and wait_lamp=1 on edge 7 after first high sample; ped_walk=1 -> both 0 next cycle.
REQ-028 Bounce: btn_raw toggles every cycle for 10 cycles then returns 0 -> ped_button stays 0 throughout.
REQ-029 Lockout: after ped_walk 1->0, press held during the 8 LOCKOUT cycles -> no request; fresh press after IDLE -> ped_button=1 after 7 edges.
REQ-030 Simultaneous: press edge and ped_walk=1 same IDLE cycle -> REQ one cycle (ped_button=1), then SERVE.
REQ-031 Reset mid-REQ: reset=1 for one cycle -> ped_button=0, wait_lamp=0 next edge; btn_raw still held high -> no new request until released and re-pressed.
REQ-032 With PED_PRESS_STATS_EN: 3 accepted presses -> press_count=3; presses during LOCKOUT do not increment.
